// File: rtl/dip_pkg.sv
// Shared constants for the binary dilation stage: pixel encodings, counter
// width and 3x3 tap indices (row-major, top-left = 0).
package dip_pkg;

  localparam int unsigned PIX_W = 16;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned PIX_BIT = 15;
  localparam int unsigned TAP_N = 9;

  localparam logic [PIX_W-1:0] PIX_WHITE = 16'hFFFF;
  localparam logic [PIX_W-1:0] PIX_BLACK = 16'h0000;

  localparam int unsigned TAP_TL = 0;
  localparam int unsigned TAP_TM = 1;
  localparam int unsigned TAP_TR = 2;
  localparam int unsigned TAP_ML = 3;
  localparam int unsigned TAP_MM = 4;
  localparam int unsigned TAP_MR = 5;
  localparam int unsigned TAP_BL = 6;
  localparam int unsigned TAP_BM = 7;
  localparam int unsigned TAP_BR = 8;

endpackage

// File: rtl/dip_dilation_if.sv
// Pixel stream in (from erosion) and dilated stream out (to the SDRAM write FIFO).
interface dip_dilation_if;
  import dip_pkg::*;

  logic             dip_en;
  logic [PIX_W-1:0] dip_data;
  logic             sdram_wr_en;
  logic [PIX_W-1:0] sdram_wr_data;

  modport master (output dip_en, dip_data, input sdram_wr_en, sdram_wr_data);
  modport slave  (input dip_en, dip_data, output sdram_wr_en, sdram_wr_data);
endinterface

// File: rtl/dilation_window_3x3_1bit.sv
// Position counters, two 1-bit line buffers and a 3x3 shift window whose taps
// are masked at frame boundaries; centre is (row-1, col-1) of the accepted pixel.
module dilation_window_3x3_1bit
  import dip_pkg::*;
#(
  parameter logic [CNT_W-1:0] CNT_COL_MAX = 16'd1023,
  parameter logic [CNT_W-1:0] CNT_ROW_MAX = 16'd767
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_bit,
  output logic [TAP_N-1:0] o_taps_c,
  output logic             o_any_valid,
  output logic             o_data_en
);

  localparam int unsigned DEPTH = 32'(CNT_COL_MAX) + 1;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CNT_W-1:0] r_cnt_col;
  logic [CNT_W-1:0] r_cnt_row;
  logic             r_lb1 [DEPTH];
  logic             r_lb2 [DEPTH];
  logic [AW-1:0]    w_addr;
  logic             w_lb1_rd;
  logic             w_lb2_rd;
  // Window rows: bit 2 = column c-2, bit 1 = c-1, bit 0 = c
  logic [2:0]       r_top;
  logic [2:0]       r_mid;
  logic [2:0]       r_bot;
  logic             r_mask_top;
  logic             r_mask_mid;
  logic             r_mask_left;
  logic             r_centre_ok;
  logic             r_data_en;
  logic [2:0]       w_col_ok;
  logic [2:0]       w_top;
  logic [2:0]       w_mid;
  logic [2:0]       w_bot;

  assign w_addr   = r_cnt_col[AW-1:0];
  assign w_lb1_rd = r_lb1[w_addr];
  assign w_lb2_rd = r_lb2[w_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt_col <= '0;
      r_cnt_row <= '0;
    end else if (i_en) begin
      if (r_cnt_col == CNT_COL_MAX) begin
        r_cnt_col <= '0;
        r_cnt_row <= (r_cnt_row == CNT_ROW_MAX) ? '0 : r_cnt_row + CNT_W'(1);
      end else begin
        r_cnt_col <= r_cnt_col + CNT_W'(1);
      end
    end
  end

  // Line-buffer cascade; contents are never cleared, stale rows are masked instead
  always_ff @(posedge clk) begin
    if (i_en) begin
      r_lb1[w_addr] <= i_bit;
      r_lb2[w_addr] <= w_lb1_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_top       <= '0;
      r_mid       <= '0;
      r_bot       <= '0;
      r_mask_top  <= 1'b0;
      r_mask_mid  <= 1'b0;
      r_mask_left <= 1'b0;
      r_centre_ok <= 1'b0;
      r_data_en   <= 1'b0;
    end else begin
      r_data_en <= i_en;
      if (i_en) begin
        r_top       <= {r_top[1:0], w_lb2_rd};
        r_mid       <= {r_mid[1:0], w_lb1_rd};
        r_bot       <= {r_bot[1:0], i_bit};
        r_mask_top  <= (r_cnt_row < CNT_W'(2));
        r_mask_mid  <= (r_cnt_row == '0);
        r_mask_left <= (r_cnt_col < CNT_W'(2));
        r_centre_ok <= (r_cnt_row != '0) && (r_cnt_col != '0);
      end
    end
  end

  always_comb begin
    w_col_ok = {~r_mask_left, 2'b11};
    w_top    = r_top & w_col_ok & {3{~r_mask_top}};
    w_mid    = r_mid & w_col_ok & {3{~r_mask_mid}};
    w_bot    = r_bot & w_col_ok;
    o_taps_c = '0;
    o_taps_c[TAP_TL] = w_top[2];
    o_taps_c[TAP_TM] = w_top[1];
    o_taps_c[TAP_TR] = w_top[0];
    o_taps_c[TAP_ML] = w_mid[2];
    o_taps_c[TAP_MM] = w_mid[1];
    o_taps_c[TAP_MR] = w_mid[0];
    o_taps_c[TAP_BL] = w_bot[2];
    o_taps_c[TAP_BM] = w_bot[1];
    o_taps_c[TAP_BR] = w_bot[0];
  end

  assign o_any_valid = r_centre_ok;
  assign o_data_en   = r_data_en;

endmodule

// File: rtl/dip_dilation.sv
// Binary dilation (square 3x3, or 4-connected cross when DILATE_CROSS_EN is
// defined) on a 1-bit pixel stream; output valid is input valid delayed 2 clocks.
module dip_dilation
  import dip_pkg::*;
#(
  parameter logic [CNT_W-1:0] CNT_COL_MAX = 16'd1023,
  parameter logic [CNT_W-1:0] CNT_ROW_MAX = 16'd767
) (
  input  logic           clk,
  input  logic           rst,
  dip_dilation_if.slave  bus
);

  logic [TAP_N-1:0] w_taps;
  logic             w_any_valid;
  logic             w_data_en;
  logic             w_hit;
  logic             r_wr_en;
  logic [PIX_W-1:0] r_wr_data;

  dilation_window_3x3_1bit #(
    .CNT_COL_MAX (CNT_COL_MAX),
    .CNT_ROW_MAX (CNT_ROW_MAX)
  ) u_window (
    .clk         (clk),
    .rst         (rst),
    .i_en        (bus.dip_en),
    .i_bit       (bus.dip_data[PIX_BIT]),
    .o_taps_c    (w_taps),
    .o_any_valid (w_any_valid),
    .o_data_en   (w_data_en)
  );

`ifdef DILATE_CROSS_EN
  assign w_hit = w_any_valid & (w_taps[TAP_TM] | w_taps[TAP_ML] | w_taps[TAP_MM] |
                                w_taps[TAP_MR] | w_taps[TAP_BM]);
`else
  assign w_hit = w_any_valid & (|w_taps);
`endif

  // Second valid stage; data holds its last value between valid pixels
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_en   <= 1'b0;
      r_wr_data <= PIX_BLACK;
    end else begin
      r_wr_en <= w_data_en;
      if (w_data_en) begin
        r_wr_data <= w_hit ? PIX_WHITE : PIX_BLACK;
      end
    end
  end

  assign bus.sdram_wr_en   = r_wr_en;
  assign bus.sdram_wr_data = r_wr_data;

endmodule

// File: tb/tb_dip_dilation.sv
// Scoreboard bench for dip_dilation on an 8x6 frame; expected pixels come from
// a geometric dilation model of the driven image (cross when DILATE_CROSS_EN).
module tb_dip_dilation;
  import dip_pkg::*;

  localparam int ROWS = 6;
  localparam int COLS = 8;
`ifdef DILATE_CROSS_EN
  localparam int SINGLE_WHITE = 5;
  localparam int EDGE7_WHITE  = 1;
`else
  localparam int SINGLE_WHITE = 9;
  localparam int EDGE7_WHITE  = 3;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  dip_dilation_if bus ();

  dip_dilation #(
    .CNT_COL_MAX (16'd7),
    .CNT_ROW_MAX (16'd5)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  bit          img [ROWS][COLS];
  logic [15:0] exp_q [$];
  logic [15:0] exp_pop;
  logic [15:0] hold_exp = 16'h0;
  logic        pend1 = 1'b0;
  logic        pend2 = 1'b0;
  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;
  int n_white = 0;
  int tr = 0;
  int tc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_pix(input int r, input int c);
    int y;
    int x;
    if (r == 0 || c == 0) return PIX_BLACK;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
`ifdef DILATE_CROSS_EN
        if (dr != 0 && dc != 0) continue;
`endif
        y = r - 1 + dr;
        x = c - 1 + dc;
        if (y >= 0 && x >= 0 && img[y][x]) return PIX_WHITE;
      end
    end
    return PIX_BLACK;
  endfunction

  // Output monitor: valid timing, scoreboard data and hold-between-pixels
  always @(negedge clk) begin
    check("wr_en_lat2", 32'(bus.sdram_wr_en), 32'(pend2));
    if (bus.sdram_wr_en) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        exp_pop = exp_q.pop_front();
        check("wr_data", 32'(bus.sdram_wr_data), 32'(exp_pop));
        hold_exp = exp_pop;
        n_out++;
        if (bus.sdram_wr_data == PIX_WHITE) n_white++;
      end
    end else begin
      check("wr_data_hold", 32'(bus.sdram_wr_data), 32'(hold_exp));
    end
    pend2 = pend1;
    pend1 = rst ? 1'b0 : bus.dip_en;
    if (rst) begin
      pend2    = 1'b0;
      hold_exp = PIX_BLACK;
      exp_q.delete();
    end
  end

  task automatic clear_img(input bit v);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        img[r][c] = v;
  endtask

  task automatic drive(input int n, input bit gap, input bit tail);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.dip_en   = 1'b1;
      bus.dip_data = img[tr][tc] ? PIX_WHITE : PIX_BLACK;
      exp_q.push_back(exp_pix(tr, tc));
      if (tc == COLS - 1) begin
        tc = 0;
        tr = (tr == ROWS - 1) ? 0 : tr + 1;
      end else begin
        tc++;
      end
      if (gap) begin
        @(posedge clk); #1;
        bus.dip_en = 1'b0;
      end
    end
    if (tail) begin
      @(posedge clk); #1;
      bus.dip_en = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic start_counts();
    n_out   = 0;
    n_white = 0;
  endtask

  initial begin
    bus.dip_en   = 1'b0;
    bus.dip_data = PIX_BLACK;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_en", 32'(bus.sdram_wr_en), 32'd0);
    check("rst_wr_data", 32'(bus.sdram_wr_data), 32'd0);
    rst = 1'b0;

    // Single white pixel, continuous stream
    clear_img(1'b0);
    img[2][3] = 1'b1;
    start_counts();
    drive(48, 1'b0, 1'b1);
    drain();
    check("t1_white", 32'(n_white), 32'(SINGLE_WHITE));
    check("t1_count", 32'(n_out), 32'd48);

    // All-white frame: only row 0 / column 0 centres are black
    clear_img(1'b1);
    start_counts();
    drive(48, 1'b0, 1'b1);
    drain();
    check("t2_white", 32'(n_white), 32'd35);
    check("t2_count", 32'(n_out), 32'd48);

    // Same single pixel with dip_en toggling
    clear_img(1'b0);
    img[2][3] = 1'b1;
    start_counts();
    drive(48, 1'b1, 1'b1);
    drain();
    check("t3_white", 32'(n_white), 32'(SINGLE_WHITE));
    check("t3_count", 32'(n_out), 32'd48);

    // Last row white, then a black frame must stay black across the wrap
    clear_img(1'b0);
    for (int c = 0; c < COLS; c++) img[ROWS-1][c] = 1'b1;
    drive(48, 1'b0, 1'b1);
    drain();
    clear_img(1'b0);
    start_counts();
    drive(48, 1'b0, 1'b1);
    drain();
    check("t4_white", 32'(n_white), 32'd0);
    check("t4_count", 32'(n_out), 32'd48);

    // Reset mid-row 3 with a pixel in flight
    clear_img(1'b0);
    img[2][3] = 1'b1;
    drive(28, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.dip_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    tr = 0;
    tc = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("t5_wr_en", 32'(bus.sdram_wr_en), 32'd0);
      check("t5_wr_data", 32'(bus.sdram_wr_data), 32'd0);
    end
    start_counts();
    drive(48, 1'b0, 1'b1);
    drain();
    check("t5_white", 32'(n_white), 32'(SINGLE_WHITE));
    check("t5_count", 32'(n_out), 32'd48);

    // White at last column must not leak into column 0 of the next row
    clear_img(1'b0);
    img[3][7] = 1'b1;
    start_counts();
    drive(48, 1'b0, 1'b1);
    drain();
    check("t6_white", 32'(n_white), 32'(EDGE7_WHITE));
    check("t6_count", 32'(n_out), 32'd48);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dip_dilation.md
Name: dip_dilation

Overview:
Binary dilation stage placed directly downstream of the erosion stage to form a morphological opening (erode then dilate) on the Sobel edge map. Consumes the 16-bit binary pixel stream that erosion produces for SDRAM. Emits a dilated 16-bit stream with the same per-pixel handshake, ready for the SDRAM write FIFO.

Parameters:
CNT_COL_MAX, 16'd1023, last column index (line width minus 1)
CNT_ROW_MAX, 16'd767, last row index (frame height minus 1)

Ports:
clk  input  1  system clock; all logic on its rising edge
rst  input  1  synchronous, active-high reset
dip_en  input  1  input pixel valid, one pixel per asserted cycle; gaps allowed
dip_data  input  16  binary pixel: 16'hFFFF white, 16'h0000 black; only bit 15 is used
sdram_wr_en  output  1  output pixel valid
sdram_wr_data  output  16  dilated pixel: 16'hFFFF or 16'h0000

Behaviour:
- Reset (rst=1 at a clock edge) clears the following:
  - cnt_col, cnt_row, window registers, valid pipeline, sdram_wr_en and sdram_wr_data (all 0).
  - Line-buffer RAM contents are not cleared. Stale data is hidden by the row masks below.
- Counters:
  - cnt_col increments on each dip_en and wraps from CNT_COL_MAX to 0.
  - cnt_row increments when cnt_col wraps, and wraps from CNT_ROW_MAX to 0 at frame end.
  - Both counters hold while dip_en=0.
- Line buffers:
  - Two 1-bit buffers, depth CNT_COL_MAX+1, form a cascade (current row → row-1 → row-2).
  - Read and write happen only on dip_en.
- Window:
  - A 3x3 shift window advances only on dip_en.
  - The window centre is the pixel at (cnt_row-1, cnt_col-1) relative to the accepted input.
  - The output frame is therefore shifted by +1 row and +1 column. The last input row and column are never centres.
- Boundary masks (masked taps read as 0), evaluated from the counter values of the accepted pixel:
  - top-row taps masked when cnt_row<2
  - middle-row taps masked when cnt_row<1
  - left-column taps masked when cnt_col<2
  - centre outside frame (cnt_row==0 or cnt_col==0) forces the output to black
- Result: OR of the nine unmasked taps. 1 → 16'hFFFF, 0 → 16'h0000.
- Latency and handshake:
  - sdram_wr_en is dip_en delayed exactly 2 clocks, independent of gaps.
  - sdram_wr_data is valid while sdram_wr_en=1 and holds its last value otherwise.
  - Output count equals input count, one for one.
- No backpressure. The downstream FIFO must absorb the full input rate.
- Frame wrap: the first pixel of a new frame (row 0) gets the full top mask, so the previous frame never leaks in.
- Reset mid-frame: the next accepted pixel is treated as (0,0). In-flight outputs are dropped because the valid pipeline is cleared.

Optional Feature:
Macro DILATE_CROSS_EN.
- Defined: 4-connected cross structuring element. The OR covers centre, up, down, left and right only; the corner taps are ignored. Masking, latency and handshake are unchanged.
- Undefined: full 3x3 square (default).

Decomposition:
- Package dip_pkg: constants PIX_WHITE=16'hFFFF, PIX_BLACK=16'h0000, PIX_BIT=15, and the 3x3 tap index constants.
- Sub-module dilation_window_3x3_1bit holds:
  - the counters
  - both line buffers
  - the shift window
  - the boundary masks
- It outputs nine masked taps, an any-valid flag and a data_en strobe.
- The top module holds the OR/cross reduction, the output register and the second valid stage.

Test Plan:
Test parameters: CNT_COL_MAX=7, CNT_ROW_MAX=5 (8x6 frame).
1. Single white pixel at input (2,3) in an all-black frame, dip_en continuous → white outputs exactly at output centres (1..3, 2..4), 9 pixels. With DILATE_CROSS_EN: 5 pixels (centre (2,3) plus its four neighbours).
2. All-white frame → every output 16'hFFFF except row 0 and column 0 centres (16'h0000). 48 sdram_wr_en pulses.
3. dip_en toggling 1,0,1,0 across a full frame → sdram_wr_en pattern equals dip_en delayed 2 cycles. Data identical to scenario 1.
4. Frame 1 with input row 5 all white, then frame 2 all black → no white output in frame 2. Checks the top mask at wrap.
5. rst=1 for 1 cycle mid-row 3 → sdram_wr_en=0 and sdram_wr_data=0 in the next 2 cycles. Following pixels are indexed from (0,0).
6. White pixel at input (3,7), then (4,0) black → the output at centre (3,0) of the next row stays black (left mask; no wrap-around leakage from column 7).
